// File: rtl/collector_port_scheduler_if.sv
// Bundle of every handshake/bus signal around the collector port scheduler.
//   req_*     : flit sources (router ejection ports) -> scheduler
//   col_*     : scheduler <-> NoC packet collector
//   pkt_*     : held packet stream -> core-side consumer
//   delivered_cnt / overflow_err : status
// Modports: slave = the scheduler itself, master = the environment around it.
interface collector_port_scheduler_if #(
   parameter int NODE_COUNT      = 8,
   parameter int PACKET_ID_WIDTH = 5,
   parameter int REQ_COUNT       = 4
);
   localparam int NODE_W = $clog2(NODE_COUNT);
   localparam int ID_W   = PACKET_ID_WIDTH;
   localparam int FLIT_W = 2*NODE_W + ID_W + 19;

   logic [REQ_COUNT-1:0]        req_valid;
   logic [REQ_COUNT*FLIT_W-1:0] req_flit;
   logic [REQ_COUNT-1:0]        req_ready;
   logic [FLIT_W:0]             col_flit;
   logic                        col_ready;
   logic                        col_send;
   logic                        col_valid_out;
   logic [67:0]                 col_packet;
   logic [NODE_W-1:0]           col_node_start;
   logic [NODE_W-1:0]           col_node_dest;
   logic [ID_W-1:0]             col_packet_id;
   logic                        pkt_valid;
   logic                        pkt_ready;
   logic [67:0]                 pkt_data;
   logic [NODE_W-1:0]           pkt_node_start;
   logic [NODE_W-1:0]           pkt_node_dest;
   logic [ID_W-1:0]             pkt_id;
   logic [15:0]                 delivered_cnt;
   logic                        overflow_err;

   modport slave (
      input  req_valid, req_flit, col_ready, col_valid_out, col_packet,
             col_node_start, col_node_dest, col_packet_id, pkt_ready,
      output req_ready, col_flit, col_send, pkt_valid, pkt_data,
             pkt_node_start, pkt_node_dest, pkt_id, delivered_cnt, overflow_err
   );

   modport master (
      output req_valid, req_flit, col_ready, col_valid_out, col_packet,
             col_node_start, col_node_dest, col_packet_id, pkt_ready,
      input  req_ready, col_flit, col_send, pkt_valid, pkt_data,
             pkt_node_start, pkt_node_dest, pkt_id, delivered_cnt, overflow_err
   );
endinterface

// File: rtl/collector_port_scheduler.sv
// Collector port scheduler.
//   Ingress: round-robin arbitration of REQ_COUNT flit sources into a one-entry
//            output register feeding the collector's single flit input.
//   Egress : drives the collector's send_signal and turns its one-cycle
//            valid_out pulse into a held valid/ready packet for the consumer.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (wins over ce)
//   ce   : clock enable, freezes all state when low
//   bus  : collector_port_scheduler_if.slave (req_*, col_*, pkt_*, status)
//
// Egress state (derived from in_flight / pkt_valid):
//   state            | meaning
//   idle  (0,0)      | col_send asserted, waiting to request a packet
//   sent  (1,0)      | one cycle after a send; col_send held low
//   hold  (x,1)      | packet held for consumer; no new send until popped
module collector_port_scheduler #(
   parameter int NODE_COUNT      = 8,
   parameter int PACKET_ID_WIDTH = 5,
   parameter int REQ_COUNT       = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ce,
   collector_port_scheduler_if.slave     bus
);
   localparam int NODE_W = $clog2(NODE_COUNT);
   localparam int ID_W   = PACKET_ID_WIDTH;
   localparam int FLIT_W = 2*NODE_W + ID_W + 19;
   localparam int PTR_W  = $clog2(REQ_COUNT);

   logic [FLIT_W-1:0]    out_q;
   logic                 out_valid;
   logic [PTR_W-1:0]     rr_ptr;
   logic                 in_flight;
   logic                 pkt_valid;
   logic [67:0]          pkt_data;
   logic [NODE_W-1:0]    pkt_node_start;
   logic [NODE_W-1:0]    pkt_node_dest;
   logic [ID_W-1:0]      pkt_id;
   logic [15:0]          delivered_cnt;
   logic                 overflow_err;

   logic                 can_load;
   logic                 accept;
   logic                 grant_found;
   logic [PTR_W-1:0]     grant_idx;
   logic [PTR_W-1:0]     grant_next;
   logic [FLIT_W-1:0]    grant_flit;
   logic [REQ_COUNT-1:0] req_ready_c;
   logic [PTR_W:0]       scan_sum;
   logic [PTR_W-1:0]     scan_idx;
   logic                 col_send_c;
   logic                 pop;

   // rst gates the combinational outputs so a reset cycle never shows a grant
   // or a send request.
   assign can_load   = ce && !rst && (!out_valid || bus.col_ready);
   assign accept     = ce && out_valid && bus.col_ready;
   assign col_send_c = ce && !rst && !pkt_valid && !in_flight;
   assign pop        = ce && pkt_valid && bus.pkt_ready;

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      grant_flit  = '0;
      req_ready_c = '0;
      scan_sum    = '0;
      scan_idx    = '0;
      if (can_load) begin
         for (int i = 0; i < REQ_COUNT; i++) begin
            scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (scan_sum >= (PTR_W+1)'(REQ_COUNT))
               scan_sum = scan_sum - (PTR_W+1)'(REQ_COUNT);
            scan_idx = scan_sum[PTR_W-1:0];
            if (!grant_found && bus.req_valid[scan_idx]) begin
               grant_found           = 1'b1;
               grant_idx             = scan_idx;
               grant_flit            = bus.req_flit[int'(scan_idx)*FLIT_W +: FLIT_W];
               req_ready_c[scan_idx] = 1'b1;
            end
         end
      end
   end

   assign grant_next = (grant_idx == PTR_W'(REQ_COUNT-1)) ? '0 : grant_idx + PTR_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q          <= '0;
         out_valid      <= 1'b0;
         rr_ptr         <= '0;
         in_flight      <= 1'b0;
         pkt_valid      <= 1'b0;
         pkt_data       <= '0;
         pkt_node_start <= '0;
         pkt_node_dest  <= '0;
         pkt_id         <= '0;
         delivered_cnt  <= '0;
         overflow_err   <= 1'b0;
      end else if (ce) begin
         if (grant_found) begin
            out_valid <= 1'b1;
            out_q     <= grant_flit;
            rr_ptr    <= grant_next;
         end else if (accept) begin
            out_valid <= 1'b0;
         end

         in_flight <= col_send_c;

         if (pop)
            delivered_cnt <= delivered_cnt + 16'd1;

         // A pulse landing on the pop cycle takes the freed slot, so pkt_valid
         // stays set and nothing is dropped.
         if (bus.col_valid_out && (!pkt_valid || pop)) begin
            pkt_valid      <= 1'b1;
            pkt_data       <= bus.col_packet;
            pkt_node_start <= bus.col_node_start;
            pkt_node_dest  <= bus.col_node_dest;
            pkt_id         <= bus.col_packet_id;
         end else if (bus.col_valid_out) begin
            overflow_err <= 1'b1;
         end else if (pop) begin
            pkt_valid <= 1'b0;
         end
      end
   end

   assign bus.req_ready      = req_ready_c;
   assign bus.col_flit       = {out_valid, out_q};
   assign bus.col_send       = col_send_c;
   assign bus.pkt_valid      = pkt_valid;
   assign bus.pkt_data       = pkt_data;
   assign bus.pkt_node_start = pkt_node_start;
   assign bus.pkt_node_dest  = pkt_node_dest;
   assign bus.pkt_id         = pkt_id;
   assign bus.delivered_cnt  = delivered_cnt;
   assign bus.overflow_err   = overflow_err;
endmodule

// File: tb/tb_collector_port_scheduler.sv
module tb_collector_port_scheduler;
   localparam int NODE_COUNT = 8;
   localparam int ID_W       = 5;
   localparam int REQ_COUNT  = 4;
   localparam int NODE_W     = $clog2(NODE_COUNT);
   localparam int FLIT_W     = 2*NODE_W + ID_W + 19;
   localparam logic [67:0] PKT_A = 68'hA_BCDE_F012_3456_789A;
   localparam logic [67:0] PKT_B = 68'h5_5555_0000_FFFF_1234;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ce  = 1'b0;
   always #5 clk = ~clk;

   collector_port_scheduler_if #(.NODE_COUNT(NODE_COUNT), .PACKET_ID_WIDTH(ID_W),
                                 .REQ_COUNT(REQ_COUNT)) bus ();

   collector_port_scheduler #(.NODE_COUNT(NODE_COUNT), .PACKET_ID_WIDTH(ID_W),
                              .REQ_COUNT(REQ_COUNT)) dut (
      .clk(clk), .rst(rst), .ce(ce), .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: transaction-level view of the scheduler's visible state.
   logic              m_out_valid;
   logic [FLIT_W-1:0] m_out_flit;
   int                m_rr;
   logic              m_sent_last;
   logic              m_pkt_valid;
   logic [67:0]       m_pkt;
   logic [NODE_W-1:0] m_ns, m_nd;
   logic [ID_W-1:0]   m_id;
   logic [15:0]       m_cnt;
   logic              m_ovf;

   // Egress stimulus for the next step.
   logic [67:0]       g_pkt;
   logic [NODE_W-1:0] g_ns, g_nd;
   logic [ID_W-1:0]   g_id;

   // Observations saved by the last step.
   logic [REQ_COUNT-1:0] s_rdy;
   logic                 s_send;
   logic [15:0]          s_cnt;
   logic [67:0]          s_pkt;
   logic                 s_ovf;
   logic                 s_pkt_valid;
   logic [FLIT_W:0]      s_flit;

   task automatic model_reset();
      m_out_valid = 1'b0; m_out_flit = '0; m_rr = 0; m_sent_last = 1'b0;
      m_pkt_valid = 1'b0; m_pkt = '0; m_ns = '0; m_nd = '0; m_id = '0;
      m_cnt = '0; m_ovf = 1'b0;
   endtask

   task automatic step(input logic i_rst, input logic i_ce, input logic [REQ_COUNT-1:0] v,
                       input logic cr, input logic pr, input logic cvo);
      logic [REQ_COUNT-1:0] exp_rdy;
      logic                 open_slot, exp_send, pop;
      logic [FLIT_W-1:0]    flits [REQ_COUNT];
      int                   win;
      @(negedge clk);
      rst = i_rst; ce = i_ce;
      bus.req_valid = v; bus.col_ready = cr; bus.pkt_ready = pr; bus.col_valid_out = cvo;
      for (int k = 0; k < REQ_COUNT; k++) begin
         flits[k] = FLIT_W'($urandom);
         bus.req_flit[k*FLIT_W +: FLIT_W] = flits[k];
      end
      bus.col_packet = g_pkt; bus.col_node_start = g_ns;
      bus.col_node_dest = g_nd; bus.col_packet_id = g_id;
      #1;
      win = -1;
      open_slot = !i_rst && i_ce && (!m_out_valid || cr);
      if (open_slot)
         for (int i = 0; i < REQ_COUNT; i++)
            if (win < 0 && v[(m_rr + i) % REQ_COUNT]) win = (m_rr + i) % REQ_COUNT;
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      exp_send = !i_rst && i_ce && !m_pkt_valid && !m_sent_last;

      check("req_ready", bus.req_ready, exp_rdy);
      check("col_flit", bus.col_flit, {m_out_valid, m_out_flit});
      check("col_send", bus.col_send, exp_send);
      check("pkt_valid", bus.pkt_valid, m_pkt_valid);
      check("pkt_data", bus.pkt_data, m_pkt);
      check("pkt_meta", {bus.pkt_node_start, bus.pkt_node_dest, bus.pkt_id}, {m_ns, m_nd, m_id});
      check("delivered_cnt", bus.delivered_cnt, m_cnt);
      check("overflow_err", bus.overflow_err, m_ovf);
      s_rdy = bus.req_ready; s_send = bus.col_send; s_cnt = bus.delivered_cnt;
      s_pkt = bus.pkt_data; s_ovf = bus.overflow_err; s_pkt_valid = bus.pkt_valid;
      s_flit = bus.col_flit;

      if (i_rst) begin
         model_reset();
      end else if (i_ce) begin
         if (win >= 0) begin
            m_out_valid = 1'b1; m_out_flit = flits[win]; m_rr = (win + 1) % REQ_COUNT;
         end else if (m_out_valid && cr) begin
            m_out_valid = 1'b0;
         end
         pop = m_pkt_valid && pr;
         if (pop) m_cnt = m_cnt + 16'd1;
         if (cvo && (!m_pkt_valid || pop)) begin
            m_pkt_valid = 1'b1; m_pkt = g_pkt; m_ns = g_ns; m_nd = g_nd; m_id = g_id;
         end else if (cvo) begin
            m_ovf = 1'b1;
         end else if (pop) begin
            m_pkt_valid = 1'b0;
         end
         m_sent_last = exp_send;
      end
      @(posedge clk);
   endtask

   task automatic rand_egress();
      g_pkt = 68'({$urandom, $urandom, $urandom});
      g_ns = NODE_W'($urandom); g_nd = NODE_W'($urandom); g_id = ID_W'($urandom);
   endtask

   initial begin
      bus.req_valid = '0; bus.req_flit = '0; bus.col_ready = 1'b0; bus.pkt_ready = 1'b0;
      bus.col_valid_out = 1'b0; bus.col_packet = '0; bus.col_node_start = '0;
      bus.col_node_dest = '0; bus.col_packet_id = '0;
      g_pkt = '0; g_ns = '0; g_nd = '0; g_id = '0;
      repeat (2) @(posedge clk);
      model_reset();

      // Reset state and first ce cycle
      step(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
      check("rst_flit", s_flit, '0);
      check("rst_pkt_valid", s_pkt_valid, 1'b0);
      check("rst_send", s_send, 1'b1);
      check("rst_cnt", s_cnt, 16'd0);

      // Fairness: 0,1,2,3,0
      step(1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0); check("fair0", s_rdy, 4'b0001);
      step(1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0); check("fair1", s_rdy, 4'b0010);
      check("fair_msb", s_flit[FLIT_W], 1'b1);
      step(1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0); check("fair2", s_rdy, 4'b0100);
      step(1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0); check("fair3", s_rdy, 4'b1000);
      step(1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0); check("fair4", s_rdy, 4'b0001);

      // Back-pressure: rr now at 1
      repeat (3) begin
         step(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
         check("bp_rdy", s_rdy, 4'b0000);
      end
      step(1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0); check("bp_release", s_rdy, 4'b0010);

      // Sparse: grant 2 moves rr to 3, then only 2 wraps back to 2
      step(1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0); check("sparse_a", s_rdy, 4'b0100);
      step(1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0); check("sparse_wrap", s_rdy, 4'b0100);
      step(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);

      // Egress from a clean reset
      step(1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0); check("eg_send0", s_send, 1'b1);
      g_pkt = PKT_A; g_ns = 3'd5; g_nd = 3'd2; g_id = 5'd17;
      step(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
      repeat (5) begin
         step(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
         check("eg_hold_data", s_pkt, PKT_A);
         check("eg_hold_send", s_send, 1'b0);
      end
      step(1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
      check("eg_cnt", s_cnt, 16'd1);
      check("eg_send_after_pop", s_send, 1'b1);

      // Overflow and ce freeze
      step(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
      g_pkt = PKT_B;
      step(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
      check("ovf_set", s_ovf, 1'b1);
      check("ovf_data", s_pkt, PKT_A);
      repeat (4) begin
         rand_egress();
         step(1'b0, 1'b0, 4'($urandom), 1'($urandom), 1'b1, 1'b1);
         check("ce_rdy", s_rdy, 4'b0000);
         check("ce_send", s_send, 1'b0);
         check("ce_data", s_pkt, PKT_A);
         check("ce_cnt", s_cnt, 16'd1);
      end
      step(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
      check("ovf_sticky", s_ovf, 1'b1);

      // Randomized traffic against the model
      step(1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 600; n++) begin
         logic r_rst, r_ce, r_cvo;
         r_rst = ($urandom_range(0, 99) == 0);
         r_ce  = ($urandom_range(0, 9) != 0);
         r_cvo = !m_pkt_valid && ($urandom_range(0, 2) == 0);
         rand_egress();
         step(r_rst, r_ce, 4'($urandom), 1'($urandom), 1'($urandom), r_cvo);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/collector_port_scheduler.md
Name: collector_port_scheduler

Overview:
- Controller wrapped around the NoC packet collector. It does two jobs.
- Ingress: round-robin arbitration of REQ_COUNT flit sources onto the collector's single flit input, honouring collector_ready.
- Egress: sequences the collector's send_signal and converts its one-cycle valid_out pulse into a held valid/ready packet stream for the core-side consumer.
- Sits between the router ejection ports and the collector, and between the collector and the consumer.

Parameters:
- NODE_COUNT, 8, NoC nodes; NODE_W = $clog2(NODE_COUNT)
- PACKET_ID_WIDTH, 5, packet id width (ID_W)
- REQ_COUNT, 4, flit sources arbitrated; 2..16
- FLIT_W, derived = 2*NODE_W + ID_W + 19: flit payload {node_dest, data[16:0], packet_id, node_start, byte_index[1:0]}, valid bit excluded

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ce  in  1  clock enable; all state frozen when low
- req_valid  in  REQ_COUNT  per-source flit valid
- req_flit  in  REQ_COUNT*FLIT_W  per-source flits; source k in bits [k*FLIT_W +: FLIT_W]
- req_ready  out  REQ_COUNT  one-hot grant/accept, combinational
- col_flit  out  1+FLIT_W  to collector input_data; MSB is the valid bit
- col_ready  in  1  collector_ready
- col_send  out  1  to collector send_signal
- col_valid_out  in  1  collector valid_out pulse
- col_packet  in  68  collector packet_out
- col_node_start  in  NODE_W  collector node_start_out
- col_node_dest  in  NODE_W  collector node_dest_out
- col_packet_id  in  ID_W  collector packet_id_out
- pkt_valid  out  1  held packet valid
- pkt_ready  in  1  consumer accepts
- pkt_data  out  68  held packet
- pkt_node_start  out  NODE_W  held packet source node
- pkt_node_dest  out  NODE_W  held packet destination node
- pkt_id  out  ID_W  held packet id
- delivered_cnt  out  16  packets handed to the consumer, wraps
- overflow_err  out  1  sticky: pulse arrived while hold register full

Behaviour:
- Reset (rst high at posedge, has priority over ce): all outputs 0, including col_flit valid, pkt_valid, delivered_cnt and overflow_err; rr_ptr=0, in_flight=0.
- ce=0: no register updates; req_ready=0; col_send=0.
- Ingress uses a one-entry output register out_q, with out_valid driving col_flit MSB.
  - accept = ce && out_valid && col_ready.
  - can_load = ce && (!out_valid || col_ready).
- Grant: when can_load, pick the first k with req_valid[k], scanning rr_ptr, rr_ptr+1, ... mod REQ_COUNT.
  - req_ready[k]=1 in the same cycle; out_q <= {1'b1, req_flit[k]}.
  - rr_ptr <= (k+1) mod REQ_COUNT.
- No requester and accept: out_valid <= 0. Not can_load: out_q held stable, all req_ready=0.
- Latency: source handshake at edge N; flit on col_flit from N+1 until accepted.
- Flits are passed unmodified; reassembly by packet id belongs to the collector, so there is no per-packet lock.
- Egress FSM, derived from in_flight and pkt_valid:
  - col_send = ce && !pkt_valid && !in_flight.
  - in_flight <= col_send, so it is set for exactly one cycle after each send.
- Capture: when col_valid_out && ce:
  - if !pkt_valid, load the pkt_* outputs from the col_* inputs and set pkt_valid;
  - else set overflow_err and drop the packet.
- Pop: when pkt_valid && pkt_ready && ce, clear pkt_valid and do delivered_cnt+1 mod 2^16.
- Pop and capture in the same cycle cannot both occur by construction; if they do, capture wins (pkt_valid stays 1) and the count still increments.
- Throughput: at most one packet per 2 cycles (send, pulse) when the consumer is always ready.
- Reset mid-operation: any flit in out_q and any held packet are discarded, with no req_ready pulse.

Test Plan:
- Reset → col_flit=0, pkt_valid=0, col_send=1 on the first ce cycle, delivered_cnt=0.
- Fairness: all 4 req_valid held, col_ready=1 → grants 0,1,2,3,0 on consecutive cycles; col_flit MSB=1 from cycle 1.
- Back-pressure: col_ready=0 for 3 cycles with out_valid=1 → col_flit stable, req_ready=0, rr_ptr unchanged. On release, accept occurs and the next grant goes to the same cycle's winner.
- Sparse requests: only source 2 valid, rr_ptr=3 → grant 2 (wrap), rr_ptr becomes 3.
- Egress: col_valid_out with packet 68'hA_BCDE_F012_3456_789A, pkt_ready=0 for 5 cycles → pkt_data held, col_send=0. Then pkt_ready=1 → pop, delivered_cnt=1, col_send=1 next cycle.
- Overflow and ce: force col_valid_out while pkt_valid=1 → overflow_err=1 sticky, pkt_data unchanged. ce=0 for 4 cycles → all state frozen.
